gate_sweep_ctrl: RTL and testbench

- Self-test sequencer for the two-input logic-gate datapath (AND, OR, NOT A, NOT B, NAND, NOR, XOR, XNOR).
- On a start pulse it drives the gate inputs through all four (a,b) combinations and waits a programmable settle time per vector.
- After settling it samples the eight gate outputs and compares them to an internal golden model.
- It reports pass/fail, a per-gate error mask and a per-vector failure mask. It sits between the top-level control pins and the gate block.

---
 rtl/gate_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Self-test sequencer for the two-input logic-gate block. A start pulse walks
// the gate inputs through {a,b} = 00, 01, 10, 11 (gate_a is the MSB). Each
// vector is held for SETTLE_CYCLES idle cycles plus one sample cycle. In the
// sample cycle the eight gate outputs are compared against a golden model.
// Mismatches accumulate into a per-gate mask and a per-vector mask.
//
// Optional feature (macro GATE_SWEEP_LOG_EN): a 4x8 log of the raw gate_res
// captured for each vector, read combinationally through log_sel/log_data.
// Without the macro, log_data is tied to zero and log_sel is ignored.
//
// Parameters:
//   SETTLE_CYCLES  idle cycles between applying a vector and sampling it (0..15)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle sweep request, honoured only in IDLE
//   abort     in   cancel a sweep in progress (wins over start)
//   gate_res  in   gate outputs {and,or,nota,notb,nand,nor,xor,xnor}, bit 7 = and
//   gate_a    out  registered drive to gate input a
//   gate_b    out  registered drive to gate input b
//   busy      out  high while a sweep is in progress
//   done      out  one-cycle pulse on normal completion
//   pass      out  last completed sweep had no mismatches
//   err_mask  out  per-gate mismatch accumulator (gate_res bit order)
//   fail_vec  out  bit i set when vector i had any mismatch
//   vec_idx   out  current vector index
//   log_sel   in   log entry select
//   log_data  out  logged gate_res for vector log_sel
// -----------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] gate_res,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_mask,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx,
  input  logic [1:0] log_sel,
  output logic [7:0] log_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With no settle time the sequencer jumps straight to sampling.
  localparam logic       SKIP_SETTLE = (SETTLE_CYCLES == 32'd0);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  // Golden response of the gate block for one input vector.
  function automatic logic [7:0] golden_of(input logic a, input logic b);
    return {a & b, a | b, ~a, ~b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  // One-hot marker for a vector index.
  function automatic logic [3:0] vec_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t     state_r;
  logic [3:0] settle_cnt_r;
  logic       gate_a_r;
  logic       gate_b_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [7:0] err_mask_r;
  logic [3:0] fail_vec_r;
  logic [1:0] vec_idx_r;

  logic [7:0] expected_s;
  logic [7:0] diff_s;
  logic [7:0] new_err_s;
  logic       vec_fail_s;
  logic [1:0] next_vec_s;
  logic       start_ok_s;
  logic       sample_ok_s;

  // Compare the current gate outputs against the golden response.
  always_comb begin
    expected_s  = golden_of(gate_a_r, gate_b_r);
    diff_s      = gate_res ^ expected_s;
    new_err_s   = err_mask_r | diff_s;
    vec_fail_s  = |diff_s;
    next_vec_s  = vec_idx_r + 2'd1;
    start_ok_s  = (state_r == ST_IDLE) && start && !abort;
    // An abort coinciding with a sample suppresses the update.
    sample_ok_s = (state_r == ST_SAMPLE) && !abort;
  end

  // Sweep sequencer: state, vector drive, result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      gate_a_r     <= 1'b0;
      gate_b_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_mask_r   <= 8'h00;
      fail_vec_r   <= 4'h0;
      vec_idx_r    <= 2'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            vec_idx_r    <= 2'd0;
            gate_a_r     <= 1'b0;
            gate_b_r     <= 1'b0;
            err_mask_r   <= 8'h00;
            fail_vec_r   <= 4'h0;
            pass_r       <= 1'b0;
            busy_r       <= 1'b1;
            settle_cnt_r <= SETTLE_INIT;
            state_r      <= SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            gate_a_r     <= 1'b0;
            gate_b_r     <= 1'b0;
            vec_idx_r    <= 2'd0;
            pass_r       <= 1'b0;
            settle_cnt_r <= 4'd0;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
            // Leaving at count 1 gives a dwell of exactly SETTLE_CYCLES.
            if (settle_cnt_r <= 4'd1) begin
              state_r <= ST_SAMPLE;
            end
          end
        end

        ST_SAMPLE: begin
          if (!sample_ok_s) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            gate_a_r     <= 1'b0;
            gate_b_r     <= 1'b0;
            vec_idx_r    <= 2'd0;
            pass_r       <= 1'b0;
            settle_cnt_r <= 4'd0;
          end else begin
            err_mask_r <= new_err_s;
            if (vec_fail_s) begin
              fail_vec_r <= fail_vec_r | vec_bit(vec_idx_r);
            end
            if (vec_idx_r == 2'd3) begin
              // Completion outputs are presented during the DONE cycle.
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
              pass_r    <= (new_err_s == 8'h00);
              gate_a_r  <= 1'b0;
              gate_b_r  <= 1'b0;
              vec_idx_r <= 2'd0;
            end else begin
              vec_idx_r    <= next_vec_s;
              gate_a_r     <= next_vec_s[1];
              gate_b_r     <= next_vec_s[0];
              settle_cnt_r <= SETTLE_INIT;
              state_r      <= SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          if (abort) begin
            pass_r <= 1'b0;
          end
        end

        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          gate_a_r     <= 1'b0;
          gate_b_r     <= 1'b0;
          vec_idx_r    <= 2'd0;
          settle_cnt_r <= 4'd0;
        end
      endcase
    end
  end

`ifdef GATE_SWEEP_LOG_EN
  logic [7:0] log_r [4];

  // Raw sample log, cleared when a sweep is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        log_r[i] <= 8'h00;
      end
    end else if (start_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        log_r[i] <= 8'h00;
      end
    end else if (sample_ok_s) begin
      log_r[vec_idx_r] <= gate_res;
    end
  end

  assign log_data = log_r[log_sel];
`else
  logic unused_log_sel_s;

  assign unused_log_sel_s = ^log_sel;
  assign log_data         = 8'h00;
`endif

  assign gate_a   = gate_a_r;
  assign gate_b   = gate_b_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign err_mask = err_mask_r;
  assign fail_vec = fail_vec_r;
  assign vec_idx  = vec_idx_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for gate_sweep_ctrl. A behavioural gate model with per-vector fault
// injection answers the DUT's gate drive. Expected sweep results are pushed
// into a scoreboard when a sweep is started; a monitor checks per-cycle
// behaviour and pops the scoreboard on each done pulse. A second instance
// with SETTLE_CYCLES=0 checks the shortest-latency configuration.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

  localparam int S = 2;
  localparam int N = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] gate_res;
  logic       gate_a, gate_b, busy, done, pass;
  logic [7:0] err_mask, log_data;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx, log_sel;

  logic       start0;
  logic [7:0] gate_res0;
  logic       gate_a0, gate_b0, busy0, done0, pass0;
  logic [7:0] err_mask0, log_data0;
  logic [3:0] fail_vec0;
  logic [1:0] vec_idx0;

  always #5 clk = ~clk;

  // Gate truth derived from the count of ones on the inputs.
  function automatic logic [7:0] gate_model(input logic [1:0] v);
    int ones;
    logic [7:0] r;
    ones = int'(v[1]) + int'(v[0]);
    r[7] = (ones == 2);
    r[6] = (ones >= 1);
    r[5] = (v[1] == 1'b0);
    r[4] = (v[0] == 1'b0);
    r[3] = (ones != 2);
    r[2] = (ones == 0);
    r[1] = (ones == 1);
    r[0] = (ones != 1);
    return r;
  endfunction

  logic [7:0] fault [4];

  assign gate_res  = gate_model({gate_a, gate_b}) ^ fault[{gate_a, gate_b}];
  assign gate_res0 = gate_model({gate_a0, gate_b0});

  gate_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_res(gate_res),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .fail_vec(fail_vec), .vec_idx(vec_idx),
    .log_sel(log_sel), .log_data(log_data)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .gate_res(gate_res0),
    .gate_a(gate_a0), .gate_b(gate_b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_mask(err_mask0), .fail_vec(fail_vec0), .vec_idx(vec_idx0),
    .log_sel(2'd0), .log_data(log_data0)
  );

  typedef struct packed {
    logic [7:0]      err;
    logic [3:0]      fv;
    logic            ps;
    logic [3:0][7:0] lg;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit              active = 1'b0;
  int              act_start = 0;
  logic [7:0]      held_err = 8'h00;
  logic [3:0]      held_fv  = 4'h0;
  logic            held_ps  = 1'b0;
  logic [3:0][7:0] held_lg  = '0;
  int              mon_k;
  exp_t            mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected result of a sweep in which only vectors with (v+1)(S+1) <= upto
  // have been sampled. upto >= N means a complete sweep.
  function automatic exp_t predict(input int upto);
    exp_t e;
    e = '0;
    for (int v = 0; v < 4; v++) begin
      if ((v + 1) * (S + 1) <= upto) begin
        e.err   = e.err | fault[v];
        e.fv[v] = (fault[v] != 8'h00);
`ifdef GATE_SWEEP_LOG_EN
        e.lg[v] = gate_model(2'(v)) ^ fault[v];
`endif
      end
    end
    e.ps = (upto >= N) && (e.err == 8'h00);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle sweep checks and scoreboard pop on done.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (active) begin
        mon_k = cyc - act_start;
        if (mon_k < N) begin
          chk("busy_in_sweep", busy, 1);
          chk("done_early", done, 0);
          chk("vector_drive", {gate_a, gate_b}, mon_k / (S + 1));
          chk("vec_idx", vec_idx, mon_k / (S + 1));
        end else begin
          chk("done_latency", done, 1);
          chk("busy_at_done", busy, 0);
          chk("gates_at_done", {gate_a, gate_b}, 0);
          chk("vec_idx_at_done", vec_idx, 0);
          if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("err_mask", err_mask, mon_e.err);
            chk("fail_vec", fail_vec, mon_e.fv);
            chk("pass", pass, mon_e.ps);
            held_err = mon_e.err;
            held_fv  = mon_e.fv;
            held_ps  = mon_e.ps;
            held_lg  = mon_e.lg;
          end
          active = 1'b0;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_gates", {gate_a, gate_b, vec_idx}, 0);
        chk("held_err_mask", err_mask, held_err);
        chk("held_fail_vec", fail_vec, held_fv);
        chk("held_pass", pass, held_ps);
        chk("log_data", log_data, held_lg[log_sel]);
      end
    end
  end

  // Start a sweep; abort_at < 0 lets it complete, otherwise abort is raised
  // at sweep offset abort_at. restart pulses start again mid-sweep.
  task automatic run_sweep(input int abort_at, input bit restart);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    act_start = cyc + 1;
    active    = 1'b1;
    log_sel   = 2'($urandom);
    if (abort_at < 0) sb_q.push_back(predict(N));
    @(negedge clk);
    start = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      abort    = 1'b1;
      active   = 1'b0;
      e        = predict(abort_at);
      held_err = e.err;
      held_fv  = e.fv;
      held_ps  = 1'b0;
      held_lg  = e.lg;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      if (restart) begin
        repeat ($urandom_range(1, N - 1)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int i = 0; i < N + 10; i++) begin
        if (!active) break;
        @(negedge clk);
      end
      chk("sweep_finished", active, 0);
      active = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      log_sel = 2'($urandom);
    end
  endtask

  task automatic clear_faults();
    for (int v = 0; v < 4; v++) fault[v] = 8'h00;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start0 = 1'b0;
    log_sel = 2'd0;
    clear_faults();
    #12;
    chk("reset_outputs", {gate_a, gate_b, busy, done, pass, err_mask, fail_vec, vec_idx}, 0);
    chk("reset_log", log_data, 0);
    chk("reset_outputs0", {gate_a0, gate_b0, busy0, done0, pass0, err_mask0, fail_vec0, vec_idx0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden sweep.
    run_sweep(-1, 1'b0);

    // xor output stuck at 0.
    for (int v = 0; v < 4; v++) fault[v] = gate_model(2'(v)) & 8'h02;
    run_sweep(-1, 1'b0);
    chk("xor_stuck_err", err_mask, 8'h02);
    chk("xor_stuck_fv", fail_vec, 4'b0110);

    // Abort while vector 2 is settling, then a full golden sweep.
    clear_faults();
    run_sweep(2 * (S + 1), 1'b0);
    run_sweep(-1, 1'b0);

    // Start re-pulsed mid-sweep is ignored.
    run_sweep(-1, 1'b1);

    // start and abort together in IDLE, and abort alone in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (N + 2) @(negedge clk);

    // Randomised sweeps with random faults, restarts and aborts.
    for (int n = 0; n < 30; n++) begin
      for (int v = 0; v < 4; v++)
        fault[v] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 3) == 0) run_sweep($urandom_range(0, N - 1), 1'b0);
      else run_sweep(-1, $urandom_range(0, 1) == 1);
    end

    // Zero-settle instance: done 4 edges after the start edge.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cnt = 0;
    while (!done0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("settle0_latency", cnt, 4);
    chk("settle0_pass", pass0, 1);
    chk("settle0_err", {err_mask0, fail_vec0}, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
